// File: rtl/bcd_2of5_codec.sv
// bcd_2of5_codec
// Multi-digit BCD <-> 2-out-of-5 converter. A word is accepted through a
// valid/ready handshake and converted one digit per clock, least significant
// slot first. The finished word and its per-digit error flags are then held
// until the consumer takes them.

module bcd_2of5_codec #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [5*NDIGITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5*NDIGITS-1:0]   out_data,
    output logic [NDIGITS-1:0]     err,
    output logic                   busy
);

    // The counter needs at least one bit, even when a word has a single digit.
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [5*NDIGITS-1:0] in_reg;
    logic                 mode_reg;
    logic [CW-1:0]        cnt;

    logic [4:0]           cur_slot;
    logic [4:0]           conv_slot;
    logic                 conv_err;

    // BCD digit to its 2-out-of-5 codeword; only called with digits 0..9.
    function automatic logic [4:0] encode_digit(input logic [3:0] bcd);
        logic [4:0] code;
        case (bcd)
            4'd0:    code = 5'b00011;
            4'd1:    code = 5'b00101;
            4'd2:    code = 5'b00110;
            4'd3:    code = 5'b01001;
            4'd4:    code = 5'b01010;
            4'd5:    code = 5'b01100;
            4'd6:    code = 5'b10001;
            4'd7:    code = 5'b10010;
            4'd8:    code = 5'b10100;
            4'd9:    code = 5'b11000;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    // Number of ones in a 5-bit slot.
    function automatic logic [2:0] popcount5(input logic [4:0] c);
        return {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]}
             + {2'b00, c[3]} + {2'b00, c[4]};
    endfunction

    // Codeword back to BCD. Every popcount-2 pattern is listed, so callers
    // only need to check the popcount to know the result is meaningful.
    function automatic logic [3:0] decode_code(input logic [4:0] code);
        logic [3:0] bcd;
        case (code)
            5'b00011: bcd = 4'd0;
            5'b00101: bcd = 4'd1;
            5'b00110: bcd = 4'd2;
            5'b01001: bcd = 4'd3;
            5'b01010: bcd = 4'd4;
            5'b01100: bcd = 4'd5;
            5'b10001: bcd = 4'd6;
            5'b10010: bcd = 4'd7;
            5'b10100: bcd = 4'd8;
            5'b11000: bcd = 4'd9;
            default:  bcd = 4'd0;
        endcase
        return bcd;
    endfunction

    // A new word may enter only from IDLE, and never while reset is asserted.
    assign in_ready = (state == IDLE) && !reset;

    // Pick the slot the counter currently points at from the latched word.
    always_comb begin
        cur_slot = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (cnt == CW'(i)) begin
                cur_slot = in_reg[5*i +: 5];
            end
        end
    end

    // Convert the selected slot in the direction latched at accept time.
    always_comb begin
        conv_slot = '0;
        conv_err  = 1'b0;
        if (!mode_reg) begin
            if (cur_slot[3:0] <= 4'd9) begin
                conv_slot = encode_digit(cur_slot[3:0]);
            end else begin
                conv_slot = 5'b00000;
                conv_err  = 1'b1;
            end
        end else begin
            if (popcount5(cur_slot) == 3'd2) begin
                conv_slot = {1'b0, decode_code(cur_slot)};
            end else begin
                conv_slot = 5'b01111;
                conv_err  = 1'b1;
            end
        end
    end

    // Control FSM plus all registered outputs; one digit is written per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_reg    <= '0;
            mode_reg  <= 1'b0;
            cnt       <= '0;
            out_data  <= '0;
            err       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg   <= in_data;
                        mode_reg <= mode;
                        cnt      <= '0;
                        out_data <= '0;
                        err      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (cnt == CW'(i)) begin
                            out_data[5*i +: 5] <= conv_slot;
                            err[i]             <= conv_err;
                        end
                    end
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
